// File: rtl/cim_op_sequencer.sv
// cim_op_sequencer
//   Sequences every access to the 4-row CAM/compute array through the row
//   decoder. One command (READ, WRITE, SEARCH, MAC) is accepted at a time on
//   a valid/ready channel. It is then walked through the precharge, word-line
//   drive, dead and sense phases. Results come back on a valid/ready response
//   channel.
//
//   Optional feature macro: SEQ_BUSY_CNT_EN
//     When defined, this adds input busy_clr and output busy_cnt[15:0]. The
//     counter counts cycles spent outside IDLE and saturates at 16'hFFFF.
//     busy_clr has priority over the increment.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//     cmd_op                00 READ, 01 WRITE, 10 SEARCH, 11 MAC
//     cmd_addr              row for READ/WRITE
//     cmd_key               search key (SEARCH) / write data (WRITE)
//     dec_mac_en, dec_read_bar, dec_addr, dec_data   decoder drive
//     wl_en                 word-line gate, high in DRIVE
//     pre_n                 active-low precharge, low in PRECH
//     sa_en                 sense-amp strobe, high in SENSE
//     wr_data               bit-line write data
//     array_out             sensed bit-lines / match lines
//     rsp_valid/rsp_ready   response handshake
//     rsp_data              result
module cim_op_sequencer #(
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [3:0] cmd_key,
  output logic       dec_mac_en,
  output logic       dec_read_bar,
  output logic [1:0] dec_addr,
  output logic [3:0] dec_data,
  output logic       wl_en,
  output logic       pre_n,
  output logic       sa_en,
  output logic [3:0] wr_data,
  input  logic [3:0] array_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data
`ifdef SEQ_BUSY_CNT_EN
  ,
  input  logic        busy_clr,
  output logic [15:0] busy_cnt
`endif
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_MAC    = 2'b11;

  localparam logic [3:0] PRE_LAST = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LAST  = 4'(WL_CYC - 1);

  // S_DEAD is the gap after DRIVE: word line off, sense amp not yet strobed.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECH,
    S_DRIVE,
    S_DEAD,
    S_SENSE,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] row_q, row_d;
  logic [1:0] op_q, op_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] rsp_data_q, rsp_data_d;
  logic       mac_en_q, mac_en_d;
  logic       read_bar_q, read_bar_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic [5:0] mac_sum;

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      mac_en_q   <= 1'b0;
      read_bar_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      mac_en_q   <= mac_en_d;
      read_bar_q <= read_bar_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state and datapath logic. Decoder drive is loaded on accept and
  // held until the sequencer returns to IDLE, where it is cleared.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    op_d       = op_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    mac_en_d   = mac_en_q;
    read_bar_d = read_bar_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_data_d  = wr_data_q;
    mac_sum    = acc_q + {2'b00, array_out};

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_PRECH;
          op_d    = cmd_op;
          cnt_d   = '0;
          row_d   = '0;
          acc_d   = '0;
          unique case (cmd_op)
            OP_READ: begin
              mac_en_d   = 1'b1;
              read_bar_d = 1'b0;
              addr_d     = cmd_addr;
            end
            OP_WRITE: begin
              mac_en_d   = 1'b1;
              read_bar_d = 1'b1;
              addr_d     = cmd_addr;
              wr_data_d  = cmd_key;
            end
            OP_SEARCH: begin
              mac_en_d = 1'b0;
              data_d   = cmd_key;
            end
            OP_MAC: begin
              mac_en_d   = 1'b1;
              read_bar_d = 1'b0;
              addr_d     = 2'd0;
            end
            default: ;
          endcase
        end
      end

      S_PRECH: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DRIVE: begin
        if (cnt_q == WL_LAST) begin
          cnt_d   = '0;
          state_d = S_DEAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // WRITE has nothing to sense, so it leaves straight from the dead cycle.
      S_DEAD: begin
        if (op_q == OP_WRITE) begin
          state_d    = S_IDLE;
          mac_en_d   = 1'b0;
          read_bar_d = 1'b0;
          addr_d     = '0;
          data_d     = '0;
          wr_data_d  = '0;
        end else begin
          state_d = S_SENSE;
        end
      end

      // MAC walks rows 0..3, restarting at PRECH for each row; the last row's
      // sample is folded straight into the response.
      S_SENSE: begin
        if (op_q == OP_MAC) begin
          if (row_q == 2'd3) begin
            rsp_data_d = mac_sum;
            acc_d      = mac_sum;
            state_d    = S_RESP;
          end else begin
            acc_d   = mac_sum;
            row_d   = row_q + 2'd1;
            addr_d  = row_q + 2'd1;
            state_d = S_PRECH;
          end
        end else begin
          rsp_data_d = {2'b00, array_out};
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          mac_en_d   = 1'b0;
          read_bar_d = 1'b0;
          addr_d     = '0;
          data_d     = '0;
          wr_data_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign pre_n        = (state_q != S_PRECH);
  assign wl_en        = (state_q == S_DRIVE);
  assign sa_en        = (state_q == S_SENSE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_data     = rsp_data_q;
  assign dec_mac_en   = mac_en_q;
  assign dec_read_bar = read_bar_q;
  assign dec_addr     = addr_q;
  assign dec_data     = data_q;
  assign wr_data      = wr_data_q;

`ifdef SEQ_BUSY_CNT_EN
  logic [15:0] busy_q, busy_d;

  // Busy-cycle counter: clear wins, otherwise count non-IDLE cycles and stick at max.
  always_comb begin
    busy_d = busy_q;
    if (busy_clr) begin
      busy_d = '0;
    end else if ((state_q != S_IDLE) && (busy_q != 16'hFFFF)) begin
      busy_d = busy_q + 16'd1;
    end
  end

  // Busy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_cnt = busy_q;
`endif

endmodule
